// File: rtl/register_file_mp.sv
// Multi-port register file: 2**N x M bits, NR read ports, NW write ports.
// Optional hardwired-zero entry 0, write-to-read bypass and registered read stage.
module register_file_mp #(
    parameter int unsigned N        = 2,
    parameter int unsigned M        = 4,
    parameter int unsigned NR       = 2,
    parameter int unsigned NW       = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned READ_LAT = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NW-1:0]   we,
    input  logic [NW*N-1:0] waddr,
    input  logic [NW*M-1:0] wd,
    input  logic [NR*N-1:0] raddr,
    output logic [NR*M-1:0] rd
);

    localparam int unsigned Depth = 2 ** N;

    logic [M-1:0]     mem_q   [Depth];
    logic [M-1:0]     mem_d   [Depth];
    logic [Depth-1:0] wr_hit;
    logic [M-1:0]     wr_data [Depth];
    logic [N-1:0]     rd_addr [NR];
    logic [NR*M-1:0]  rd_val;

    // Per-entry write resolution; ascending scan lets the highest enabled port win.
    always_comb begin
        for (int e = 0; e < Depth; e++) begin
            wr_hit[e]  = 1'b0;
            wr_data[e] = '0;
            for (int w = 0; w < NW; w++) begin
                if (we[w] && (waddr[w*N +: N] == N'(e))) begin
                    wr_hit[e]  = 1'b1;
                    wr_data[e] = wd[w*M +: M];
                end
            end
        end
        if (ZERO_REG != 0) begin
            wr_hit[0]  = 1'b0;
            wr_data[0] = '0;
        end
    end

    always_comb begin
        for (int e = 0; e < Depth; e++) begin
            mem_d[e] = wr_hit[e] ? wr_data[e] : mem_q[e];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int e = 0; e < Depth; e++) begin
                mem_q[e] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read value as seen at the coming edge: write-first when bypassing, else array contents.
    always_comb begin
        rd_val = '0;
        for (int r = 0; r < NR; r++) begin
            rd_addr[r] = raddr[r*N +: N];
            rd_val[r*M +: M] = mem_q[rd_addr[r]];
            if ((BYPASS != 0) && wr_hit[rd_addr[r]]) begin
                rd_val[r*M +: M] = wr_data[rd_addr[r]];
            end
            if ((ZERO_REG != 0) && (rd_addr[r] == '0)) begin
                rd_val[r*M +: M] = '0;
            end
        end
    end

    if (READ_LAT != 0) begin : g_rd_reg
        logic [NR*M-1:0] rd_q;
        logic [NR*M-1:0] rd_d;

        always_comb begin
            rd_d = rd_val;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                rd_q <= '0;
            end else begin
                rd_q <= rd_d;
            end
        end

        assign rd = rd_q;
    end else begin : g_rd_comb
        assign rd = rd_val;
    end

endmodule
